// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the Fifo write-port arbiter.
// State encodings, clog2 and default width localparams.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_REQUESTERS = 4;
  localparam int DEF_BURST      = 4;
  localparam int DEF_ID_W       = clog2(DEF_REQUESTERS);
  localparam int DEF_CNT_W      = clog2(DEF_BURST + 1);

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/Fifo side bundle of the write arbiter.
// master drives requests and full; slave is the arbiter.
interface fifo_write_arbiter_if #(
  parameter int p_WIDTH      = 8,
  parameter int p_REQUESTERS = 4
);
  import fifo_write_arbiter_pkg::*;

  localparam int ID_W = clog2(p_REQUESTERS);

  logic [p_REQUESTERS-1:0]         req;
  logic [p_REQUESTERS*p_WIDTH-1:0] data;
  logic                            full;
  logic [p_REQUESTERS-1:0]         ack;
  logic                            wrena;
  logic [p_WIDTH-1:0]              wrdata;
  logic                            grant_valid;
  logic [ID_W-1:0]                 grant_id;

  modport master (
    output req, data, full,
    input  ack, wrena, wrdata, grant_valid, grant_id
  );

  modport slave (
    input  req, data, full,
    output ack, wrena, wrdata, grant_valid, grant_id
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Round-robin pick: first set req bit after last, wrapping.
// Purely combinational.
module fifo_write_arbiter_rr_picker #(
  parameter int p_REQUESTERS = 4,
  parameter int ID_W         = 2
) (
  input  logic [p_REQUESTERS-1:0] req,
  input  logic [ID_W-1:0]         last,
  output logic                    any,
  output logic [ID_W-1:0]         idx
);

  // Scan farthest-first so the nearest candidate wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = p_REQUESTERS; k >= 1; k--) begin
      if (req[(int'(last) + k) % p_REQUESTERS])
        idx = ID_W'((int'(last) + k) % p_REQUESTERS);
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin sharing of one Fifo write port between producers,
// bounded bursts per grant, zero-cycle ack, full honoured.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int p_WIDTH      = DEF_WIDTH,
  parameter int p_REQUESTERS = DEF_REQUESTERS,
  parameter int p_BURST      = DEF_BURST
) (
  input  logic                clk,
  input  logic                rst,
  fifo_write_arbiter_if.slave bus
);

  localparam int ID_W  = clog2(p_REQUESTERS);
  localparam int CNT_W = clog2(p_BURST + 1);

  localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(p_BURST);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(p_REQUESTERS - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              wrena;
  logic              rel;
  logic [p_REQUESTERS-1:0] ack;

  fifo_write_arbiter_rr_picker #(
    .p_REQUESTERS (p_REQUESTERS),
    .ID_W         (ID_W)
  ) u_picker (
    .req  (bus.req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign wrena = (state_q == GRANT) & bus.req[owner_q]
               & ~bus.full & ~rst;

  always_comb begin
    ack = '0;
    ack[owner_q] = wrena;
  end

  assign bus.wrena       = wrena;
  assign bus.ack         = ack;
  assign bus.wrdata      = bus.data[owner_q*p_WIDTH +: p_WIDTH];
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_id    = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          owner_d = pick_idx;
          last_d  = pick_idx;
          count_d = '0;
        end
      end
      GRANT: begin
        // A full stall leaves owner and count untouched.
        if (wrena) begin
          if (count_q + 1'b1 == BURST_C)
            rel = 1'b1;
          else
            count_d = count_q + 1'b1;
        end else if (!bus.req[owner_q]) begin
          rel = 1'b1;
        end
        if (rel) begin
          count_d = '0;
          if (pick_any) begin
            owner_d = pick_idx;
            last_d  = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table,
// directed corner sequences, random vs model, Fifo system run.
module tb_fifo_write_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.p_WIDTH(W), .p_REQUESTERS(N)) bus();

  fifo_write_arbiter #(
    .p_WIDTH(W), .p_REQUESTERS(N), .p_BURST(B)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit m_busy;
  int m_owner;
  int m_beats;
  int m_last;

  logic         s_wrena;
  logic         s_gv;
  logic [N-1:0] s_ack;
  logic [W-1:0] s_wd;
  logic [1:0]   s_gid;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] rq, input int last);
    for (int k = 1; k <= N; k++)
      if (rq[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0] rq,
                            input logic f);
    int  p;
    bit  wr;
    bit  done;
    p = rr_pick(rq, m_last);
    if (r) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_last = N - 1;
    end else if (!m_busy) begin
      if (p >= 0) begin
        m_busy = 1; m_owner = p; m_beats = 0; m_last = p;
      end
    end else begin
      wr   = rq[m_owner] && !f;
      done = !rq[m_owner] || (wr && (m_beats + 1 == B));
      if (wr) m_beats++;
      if (done) begin
        m_beats = 0;
        if (p >= 0) begin
          m_owner = p; m_last = p;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] rq,
                       input logic f, input logic [N*W-1:0] d,
                       input bit use_model);
    logic         e_wr;
    logic [N-1:0] e_ack;
    rst      = r;
    bus.req  = rq;
    bus.full = f;
    bus.data = d;
    #3;
    s_wrena = bus.wrena;
    s_ack   = bus.ack;
    s_wd    = bus.wrdata;
    s_gv    = bus.grant_valid;
    s_gid   = bus.grant_id;
    if (use_model) begin
      e_wr  = m_busy && rq[m_owner] && !f && !r;
      e_ack = '0;
      if (e_wr) e_ack[m_owner] = 1'b1;
      chk("model_wrena", 32'(s_wrena), 32'(e_wr));
      chk("model_ack", 32'(s_ack), 32'(e_ack));
      chk("model_wrdata", 32'(s_wd), 32'(d[m_owner*W +: W]));
      chk("model_grant_valid", 32'(s_gv), 32'(m_busy));
      chk("model_grant_id", 32'(s_gid), 32'(m_owner));
    end
    @(posedge clk);
    model_edge(r, rq, f);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         full;
    logic [W-1:0] d0;
    logic         wrena;
    logic [N-1:0] ack;
    logic         gv;
    logic [1:0]   gid;
  } vec_t;

  vec_t vt[10];

  int           seq[3];
  int           rxn[3];
  bit           pend[3];
  logic [W-1:0] q[$];

  initial begin
    logic [N-1:0]   rq;
    logic [N*W-1:0] d;
    logic           f;
    logic [W-1:0]   w;
    logic [1:0]     id;
    int             cyc;
    bit             pop;

    vt[0] = '{1'b1, 4'b0000, 1'b0, 8'd7,  1'b0, 4'b0000, 1'b0, 2'd0};
    vt[1] = '{1'b0, 4'b0001, 1'b0, 8'd7,  1'b0, 4'b0000, 1'b0, 2'd0};
    vt[2] = '{1'b0, 4'b0001, 1'b0, 8'd7,  1'b1, 4'b0001, 1'b1, 2'd0};
    vt[3] = '{1'b0, 4'b0001, 1'b0, 8'd10, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[4] = '{1'b0, 4'b0001, 1'b0, 8'd13, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[5] = '{1'b0, 4'b0001, 1'b0, 8'd0,  1'b1, 4'b0001, 1'b1, 2'd0};
    vt[6] = '{1'b0, 4'b0001, 1'b0, 8'd3,  1'b1, 4'b0001, 1'b1, 2'd0};
    vt[7] = '{1'b0, 4'b0001, 1'b1, 8'd3,  1'b0, 4'b0000, 1'b1, 2'd0};
    vt[8] = '{1'b0, 4'b0000, 1'b0, 8'd3,  1'b0, 4'b0000, 1'b1, 2'd0};
    vt[9] = '{1'b0, 4'b0000, 1'b0, 8'd3,  1'b0, 4'b0000, 1'b0, 2'd0};

    // Unchecked first reset edge: DUT state is unknown before it.
    cycle(1'b1, '0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].rst, vt[i].req, vt[i].full,
            {24'd0, vt[i].d0}, 1'b1);
      chk($sformatf("vec%0d_wrena", i), 32'(s_wrena), 32'(vt[i].wrena));
      chk($sformatf("vec%0d_ack", i), 32'(s_ack), 32'(vt[i].ack));
      chk($sformatf("vec%0d_wrdata", i), 32'(s_wd), 32'(vt[i].d0));
      chk($sformatf("vec%0d_gv", i), 32'(s_gv), 32'(vt[i].gv));
      chk($sformatf("vec%0d_gid", i), 32'(s_gid), 32'(vt[i].gid));
    end

    // All four requesting: bursts of 4 in rotation, no gaps.
    cycle(1'b1, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, 4'b1111, 1'b0, $urandom, 1'b1);
    chk("rot_bubble", 32'(s_wrena), 32'd0);
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0] ea;
      ea = '0;
      ea[(k / 4) % 4] = 1'b1;
      cycle(1'b0, 4'b1111, 1'b0, $urandom, 1'b1);
      chk("rot_wrena", 32'(s_wrena), 32'd1);
      chk("rot_gid", 32'(s_gid), 32'((k / 4) % 4));
      chk("rot_ack", 32'(s_ack), 32'(ea));
    end

    // Owner 2 stalled by full mid-burst.
    cycle(1'b1, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, 4'b1100, 1'b0, $urandom, 1'b1);
    chk("stall_bubble_gv", 32'(s_gv), 32'd0);
    cycle(1'b0, 4'b1100, 1'b0, $urandom, 1'b1);
    chk("stall_first_gid", 32'(s_gid), 32'd2);
    chk("stall_first_wr", 32'(s_wrena), 32'd1);
    repeat (5) begin
      cycle(1'b0, 4'b1100, 1'b1, $urandom, 1'b1);
      chk("stall_full_wr", 32'(s_wrena), 32'd0);
      chk("stall_full_gid", 32'(s_gid), 32'd2);
    end
    repeat (3) begin
      cycle(1'b0, 4'b1100, 1'b0, $urandom, 1'b1);
      chk("stall_resume_wr", 32'(s_wrena), 32'd1);
      chk("stall_resume_gid", 32'(s_gid), 32'd2);
    end
    cycle(1'b0, 4'b1100, 1'b0, $urandom, 1'b1);
    chk("stall_rotate_gid", 32'(s_gid), 32'd3);
    chk("stall_rotate_wr", 32'(s_wrena), 32'd1);

    // Owner 1 drops req after two beats while 3 waits.
    cycle(1'b1, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, 4'b1010, 1'b0, $urandom, 1'b1);
    repeat (2) begin
      cycle(1'b0, 4'b1010, 1'b0, $urandom, 1'b1);
      chk("drop_own1_gid", 32'(s_gid), 32'd1);
      chk("drop_own1_wr", 32'(s_wrena), 32'd1);
    end
    cycle(1'b0, 4'b1000, 1'b0, $urandom, 1'b1);
    chk("drop_nowrite", 32'(s_wrena), 32'd0);
    repeat (4) begin
      cycle(1'b0, 4'b1010, 1'b0, $urandom, 1'b1);
      chk("drop_own3_gid", 32'(s_gid), 32'd3);
      chk("drop_own3_wr", 32'(s_wrena), 32'd1);
    end
    cycle(1'b0, 4'b1010, 1'b0, $urandom, 1'b1);
    chk("drop_back_to1", 32'(s_gid), 32'd1);

    // Reset in the middle of owner 3's burst.
    cycle(1'b1, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, 4'b1000, 1'b0, $urandom, 1'b1);
    repeat (2) begin
      cycle(1'b0, 4'b1000, 1'b0, $urandom, 1'b1);
      chk("rstmid_gid3", 32'(s_gid), 32'd3);
    end
    cycle(1'b1, 4'b1111, 1'b0, $urandom, 1'b1);
    chk("rstmid_wr_in_rst", 32'(s_wrena), 32'd0);
    chk("rstmid_ack_in_rst", 32'(s_ack), 32'd0);
    cycle(1'b0, 4'b1111, 1'b0, $urandom, 1'b1);
    chk("rstmid_idle", 32'(s_gv), 32'd0);
    chk("rstmid_idle_gid", 32'(s_gid), 32'd0);
    cycle(1'b0, 4'b1111, 1'b0, $urandom, 1'b1);
    chk("rstmid_first_gid", 32'(s_gid), 32'd0);
    chk("rstmid_first_wr", 32'(s_wrena), 32'd1);

    // Random stimulus against the reference model.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 59) == 0), N'($urandom),
            ($urandom_range(0, 3) == 0), $urandom, 1'b1);
    end

    // System run: 3 producers into a 7-deep Fifo with a random reader.
    cycle(1'b1, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0; rxn[i] = 0; pend[i] = 0;
    end
    cyc = 0;
    while ((rxn[0] < 20 || rxn[1] < 20 || rxn[2] < 20) && cyc < 3000) begin
      cyc++;
      rq = '0;
      d  = '0;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && seq[i] < 20 && $urandom_range(0, 1) == 1)
          pend[i] = 1;
        rq[i] = pend[i];
        d[i*W +: W] = {2'(i), 6'(seq[i])};
      end
      f   = (q.size() >= 7);
      pop = ($urandom_range(0, 2) != 0);
      cycle(1'b0, rq, f, d, 1'b1);
      chk("sys_no_write_when_full", 32'(s_wrena & f), 32'd0);
      if (pop && q.size() > 0) begin
        w  = q.pop_front();
        id = w[7:6];
        chk("sys_producer_id", 32'(id < 2'd3), 32'd1);
        if (id < 2'd3) begin
          chk("sys_order", 32'(w[5:0]), 32'(rxn[id]));
          rxn[id]++;
        end
      end
      if (s_wrena && !f) q.push_back(s_wd);
      for (int i = 0; i < 3; i++) begin
        if (s_ack[i]) begin
          pend[i] = 0;
          seq[i]++;
        end
      end
    end
    chk("sys_timeout", 32'(cyc < 3000), 32'd1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sys_count%0d", i), 32'(rxn[i]), 32'd20);
    chk("sys_fifo_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
